// File: rtl/pipe_enable_ctrl.sv
// Enable/valid sequencer for a linear chain of STAGES enable-gated data registers.
// Optional PIPE_CTRL_FLUSH_EN adds a flush_i input that abandons the current job.
//
// state | meaning
// IDLE  | waiting for start_i, chain empty
// RUN   | admitting input beats until num_beats have been accepted
// DRAIN | input closed, emptying the chain until every beat has left
// DONE  | one-cycle done pulse, then back to IDLE
module pipe_enable_ctrl #(
  parameter int STAGES = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
`ifdef PIPE_CTRL_FLUSH_EN
  input  logic              flush_i,
`endif
  input  logic              start_i,
  input  logic [CNT_W-1:0]  num_beats_i,
  output logic              busy_o,
  output logic              done_o,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [STAGES-1:0] stage_en_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [STAGES-1:0]  v_q, v_d;
  logic [CNT_W-1:0]   acc_cnt_q, acc_cnt_d;
  logic [CNT_W-1:0]   emit_cnt_q, emit_cnt_d;
  logic [CNT_W-1:0]   num_beats_q, num_beats_d;

  logic flush;
  logic advance;
  logic in_fire;
  logic out_fire;

`ifdef PIPE_CTRL_FLUSH_EN
  assign flush = flush_i;
`else
  assign flush = 1'b0;
`endif

  // Global stall: the whole chain freezes while the last stage is full and blocked.
  assign advance     = !v_q[STAGES-1] | out_ready_i;
  assign out_valid_o = v_q[STAGES-1];
  assign in_ready_o  = (state_q == RUN) & advance & (acc_cnt_q < num_beats_q) & !flush;
  assign in_fire     = in_valid_i & in_ready_o;
  assign out_fire    = out_valid_o & out_ready_i;
  assign busy_o      = (state_q == RUN) | (state_q == DRAIN);
  assign done_o      = (state_q == DONE);

  always_comb begin
    stage_en_o    = '0;
    stage_en_o[0] = in_fire;
    for (int i = 1; i < STAGES; i++) begin
      stage_en_o[i] = advance & v_q[i-1] & !flush;
    end
  end

  always_comb begin
    state_d     = state_q;
    v_d         = v_q;
    acc_cnt_d   = acc_cnt_q;
    emit_cnt_d  = emit_cnt_q;
    num_beats_d = num_beats_q;

    if (advance) begin
      v_d[0] = in_fire;
      for (int i = 1; i < STAGES; i++) begin
        v_d[i] = v_q[i-1];
      end
    end
    if (in_fire) begin
      acc_cnt_d = acc_cnt_q + CNT_W'(1);
    end
    if (out_fire) begin
      emit_cnt_d = emit_cnt_q + CNT_W'(1);
    end

    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          num_beats_d = num_beats_i;
          acc_cnt_d   = '0;
          emit_cnt_d  = '0;
          state_d     = (num_beats_i == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (in_fire && (acc_cnt_d == num_beats_q)) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (out_fire && (emit_cnt_d == num_beats_q)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (flush) begin
      state_d    = IDLE;
      v_d        = '0;
      acc_cnt_d  = '0;
      emit_cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      v_q         <= '0;
      acc_cnt_q   <= '0;
      emit_cnt_q  <= '0;
      num_beats_q <= '0;
    end else begin
      state_q     <= state_d;
      v_q         <= v_d;
      acc_cnt_q   <= acc_cnt_d;
      emit_cnt_q  <= emit_cnt_d;
      num_beats_q <= num_beats_d;
    end
  end

endmodule

// File: tb/tb_pipe_enable_ctrl.sv
// Self-checking bench for pipe_enable_ctrl: beat-level reference model plus data-order
// tracking through a bench-side register chain clocked by the DUT's stage enables.
module tb_pipe_enable_ctrl;

  localparam int S     = 4;
  localparam int CW    = 16;
  localparam int VW    = S + 4;
  localparam int P_IDLE = 0, P_RUN = 1, P_DRAIN = 2, P_DONE = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          flush_s = 1'b0;
  logic          start_i = 1'b0;
  logic [CW-1:0] num_beats_i = '0;
  logic          busy_o, done_o;
  logic          in_valid_i = 1'b0;
  logic          in_ready_o;
  logic          out_valid_o;
  logic          out_ready_i = 1'b0;
  logic [S-1:0]  stage_en_o;

  pipe_enable_ctrl #(.STAGES(S), .CNT_W(CW)) dut (
    .clk         (clk),
    .reset       (reset),
`ifdef PIPE_CTRL_FLUSH_EN
    .flush_i     (flush_s),
`endif
    .start_i     (start_i),
    .num_beats_i (num_beats_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .stage_en_o  (stage_en_o)
  );

  always #5 clk = ~clk;

  int ntests = 0;
  int nfail  = 0;

  // staged stimulus for the next cycle
  bit          c_rst = 1'b1, c_st = 1'b0, c_iv = 1'b0, c_ordy = 1'b0, c_fl = 1'b0;
  logic [CW-1:0] c_nb = '0;

  // reference model: phase, latched job size, counters, beat occupancy per slot
  int ph = P_IDLE;
  int nbq = 0, acc = 0, emit = 0;
  int pipe [S];

  // bench-side data chain
  int dreg [S];
  int ser_in = 0, ser_out = 0;

  logic [VW-1:0] exp_vec, act_vec;
  bit  data_chk;
  int  data_act, data_exp;

  // Drives one cycle of stimulus, records expected/actual outputs, advances the model.
  task automatic step();
    bit full, adv, e_ir, e_fire, ofire;
    logic [S-1:0] e_en;
    @(negedge clk);
    reset = c_rst; start_i = c_st; num_beats_i = c_nb;
    in_valid_i = c_iv; out_ready_i = c_ordy; flush_s = c_fl;
    #1;
    full   = (pipe[S-1] >= 0);
    adv    = !full || c_ordy;
    e_ir   = (ph == P_RUN) && adv && (acc < nbq) && !c_fl;
    e_fire = c_iv && e_ir;
    e_en   = '0;
    e_en[0] = e_fire;
    for (int i = 1; i < S; i++) e_en[i] = adv && (pipe[i-1] >= 0) && !c_fl;
    exp_vec = {(ph == P_RUN || ph == P_DRAIN), (ph == P_DONE), e_ir, full, e_en};
    act_vec = {busy_o, done_o, in_ready_o, out_valid_o, stage_en_o};
    ofire   = full && c_ordy;

    data_chk = out_valid_o && out_ready_i;
    data_act = dreg[S-1];
    data_exp = ser_out;
    if (data_chk) ser_out++;
    for (int i = S-1; i >= 1; i--) if (stage_en_o[i]) dreg[i] = dreg[i-1];
    if (stage_en_o[0]) begin dreg[0] = ser_in; ser_in++; end

    if (c_rst || c_fl) begin
      for (int i = 0; i < S; i++) pipe[i] = -1;
      acc = 0; emit = 0;
      if (c_rst) nbq = 0;
      ph = P_IDLE;
      ser_out = ser_in;
    end else begin
      if (adv) begin
        for (int i = S-1; i >= 1; i--) pipe[i] = pipe[i-1];
        pipe[0] = e_fire ? 1 : -1;
      end
      if (e_fire) acc++;
      if (ofire) emit++;
      case (ph)
        P_IDLE:  if (c_st) begin
                   nbq = int'(c_nb); acc = 0; emit = 0;
                   ph = (c_nb == 0) ? P_DONE : P_RUN;
                 end
        P_RUN:   if (e_fire && acc == nbq) ph = P_DRAIN;
        P_DRAIN: if (ofire && emit == nbq) ph = P_DONE;
        default: ph = P_IDLE;
      endcase
    end
  endtask

  task automatic test_reset();
    c_rst = 1; c_st = 0; c_iv = 0; c_ordy = 0; c_fl = 0;
    step();
    step();
    ntests++;
    if (act_vec !== '0) begin
      nfail++; $display("FAIL reset_outputs: got %b want %b", act_vec, {VW{1'b0}});
    end
    c_rst = 0;
    step();
    ntests++;
    if (act_vec !== exp_vec) begin
      nfail++; $display("FAIL reset_idle: got %b want %b", act_vec, exp_vec);
    end
  endtask

  task automatic test_full_rate();
    int n_ir = 0, n_of = 0, n_done = 0, first_if = -1, first_ov = -1;
    bit fin = 0;
    c_nb = 8; c_iv = 1; c_ordy = 1;
    for (int k = 0; k < 40 && !fin; k++) begin
      c_st = (k == 0);
      step();
      ntests++;
      if (act_vec !== exp_vec) begin
        nfail++; $display("FAIL full_rate cyc %0d: got %b want %b", k, act_vec, exp_vec);
      end
      if (data_chk) begin
        ntests++;
        if (data_act !== data_exp) begin
          nfail++; $display("FAIL full_rate_data: got %0d want %0d", data_act, data_exp);
        end
      end
      if (in_ready_o) n_ir++;
      if (in_ready_o && first_if < 0) first_if = k;
      if (out_valid_o && first_ov < 0) first_ov = k;
      if (out_valid_o && out_ready_i) n_of++;
      if (done_o) begin n_done++; fin = 1; end
    end
    c_st = 0;
    step();
    ntests++;
    if (n_ir != 8 || n_of != 8 || n_done != 1 || busy_o !== 1'b0) begin
      nfail++; $display("FAIL full_rate_counts: ir=%0d of=%0d done=%0d busy=%b want 8 8 1 0",
                        n_ir, n_of, n_done, busy_o);
    end
    ntests++;
    if (first_ov - first_if != S) begin
      nfail++; $display("FAIL full_rate_latency: got %0d want %0d", first_ov - first_if, S);
    end
  endtask

  task automatic test_zero_beats();
    bit any_act = 0;
    bit done_next = 0;
    c_nb = 0; c_iv = 1; c_ordy = 1;
    for (int k = 0; k < 4; k++) begin
      c_st = (k == 0);
      step();
      ntests++;
      if (act_vec !== exp_vec) begin
        nfail++; $display("FAIL zero_beats cyc %0d: got %b want %b", k, act_vec, exp_vec);
      end
      if (stage_en_o != 0 || in_ready_o) any_act = 1;
      if (k == 1) done_next = done_o;
    end
    c_st = 0;
    ntests++;
    if (any_act || !done_next) begin
      nfail++; $display("FAIL zero_beats_summary: activity=%b done_next=%b want 0 1", any_act, done_next);
    end
  endtask

  task automatic test_stall();
    int n_of = 0;
    bit fin = 0;
    c_nb = 5; c_iv = 1;
    for (int k = 0; k < 40 && !fin; k++) begin
      c_st   = (k == 0);
      c_ordy = !(k >= 6 && k <= 9);
      step();
      ntests++;
      if (act_vec !== exp_vec) begin
        nfail++; $display("FAIL stall cyc %0d: got %b want %b", k, act_vec, exp_vec);
      end
      if (data_chk) begin
        ntests++; n_of++;
        if (data_act !== data_exp) begin
          nfail++; $display("FAIL stall_data: got %0d want %0d", data_act, data_exp);
        end
      end
      if (k == 8) begin
        ntests++;
        if (out_valid_o !== 1'b1 || in_ready_o !== 1'b0 || stage_en_o !== '0) begin
          nfail++; $display("FAIL stall_frozen: ov=%b ir=%b en=%b want 1 0 0000",
                            out_valid_o, in_ready_o, stage_en_o);
        end
      end
      if (done_o) fin = 1;
    end
    c_st = 0;
    ntests++;
    if (!fin || n_of != 5) begin
      nfail++; $display("FAIL stall_summary: done=%b out_fires=%0d want 1 5", fin, n_of);
    end
  endtask

  task automatic test_bubbles();
    bit fin = 0;
    int n_of = 0;
    c_nb = 3; c_ordy = 1;
    for (int k = 0; k < 40 && !fin; k++) begin
      c_st = (k == 0);
      c_iv = (k % 2) == 1;
      step();
      ntests++;
      if (act_vec !== exp_vec) begin
        nfail++; $display("FAIL bubbles cyc %0d: got %b want %b", k, act_vec, exp_vec);
      end
      if (data_chk) begin
        ntests++; n_of++;
        if (data_act !== data_exp) begin
          nfail++; $display("FAIL bubbles_data: got %0d want %0d", data_act, data_exp);
        end
      end
      if (done_o) fin = 1;
    end
    c_st = 0;
    ntests++;
    if (!fin || n_of != 3) begin
      nfail++; $display("FAIL bubbles_summary: done=%b out_fires=%0d want 1 3", fin, n_of);
    end
  endtask

  task automatic test_reset_in_drain();
    bit fin = 0;
    c_nb = 2; c_iv = 1; c_ordy = 0;
    for (int k = 0; k < 5; k++) begin
      c_st = (k == 0);
      c_rst = (k == 4);
      step();
      ntests++;
      if (act_vec !== exp_vec) begin
        nfail++; $display("FAIL reset_drain cyc %0d: got %b want %b", k, act_vec, exp_vec);
      end
    end
    c_rst = 0; c_st = 0;
    step();
    ntests++;
    if (act_vec !== '0) begin
      nfail++; $display("FAIL reset_drain_cleared: got %b want %b", act_vec, {VW{1'b0}});
    end
    c_ordy = 1;
    for (int k = 0; k < 30 && !fin; k++) begin
      c_st = (k == 0);
      step();
      ntests++;
      if (act_vec !== exp_vec) begin
        nfail++; $display("FAIL reset_drain_rerun cyc %0d: got %b want %b", k, act_vec, exp_vec);
      end
      if (data_chk) begin
        ntests++;
        if (data_act !== data_exp) begin
          nfail++; $display("FAIL reset_drain_data: got %0d want %0d", data_act, data_exp);
        end
      end
      if (done_o) fin = 1;
    end
    c_st = 0;
    ntests++;
    if (!fin) begin
      nfail++; $display("FAIL reset_drain_timeout: done=%b want 1", fin);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 600; k++) begin
      c_st   = ($urandom_range(0, 3) == 0);
      c_nb   = CW'($urandom_range(0, 9));
      c_iv   = ($urandom_range(0, 3) != 0);
      c_ordy = ($urandom_range(0, 2) != 0);
      c_rst  = ($urandom_range(0, 150) == 0);
      step();
      ntests++;
      if (act_vec !== exp_vec) begin
        nfail++; $display("FAIL random cyc %0d: got %b want %b", k, act_vec, exp_vec);
      end
      if (data_chk) begin
        ntests++;
        if (data_act !== data_exp) begin
          nfail++; $display("FAIL random_data cyc %0d: got %0d want %0d", k, data_act, data_exp);
        end
      end
    end
    c_rst = 0; c_st = 0; c_ordy = 1;
    for (int k = 0; k < 40; k++) step();
  endtask

`ifdef PIPE_CTRL_FLUSH_EN
  task automatic test_flush();
    int fired = 0;
    bit flushed = 0, done_after = 0, fin = 0;
    c_nb = 10; c_iv = 1; c_ordy = 1;
    for (int k = 0; k < 20; k++) begin
      c_st = (k == 0);
      c_fl = (fired == 3) && !flushed;
      if (c_fl) flushed = 1;
      step();
      ntests++;
      if (act_vec !== exp_vec) begin
        nfail++; $display("FAIL flush cyc %0d: got %b want %b", k, act_vec, exp_vec);
      end
      if (in_valid_i && in_ready_o) fired++;
      if (flushed && !c_fl && done_o) done_after = 1;
    end
    c_fl = 0; c_st = 0;
    ntests++;
    if (!flushed || done_after) begin
      nfail++; $display("FAIL flush_no_done: flushed=%b done=%b want 1 0", flushed, done_after);
    end
    c_nb = 4;
    for (int k = 0; k < 30 && !fin; k++) begin
      c_st = (k == 0);
      step();
      ntests++;
      if (act_vec !== exp_vec) begin
        nfail++; $display("FAIL flush_rerun cyc %0d: got %b want %b", k, act_vec, exp_vec);
      end
      if (data_chk) begin
        ntests++;
        if (data_act !== data_exp) begin
          nfail++; $display("FAIL flush_rerun_data: got %0d want %0d", data_act, data_exp);
        end
      end
      if (done_o) fin = 1;
    end
    c_st = 0;
    ntests++;
    if (!fin) begin
      nfail++; $display("FAIL flush_rerun_timeout: done=%b want 1", fin);
    end
  endtask
`endif

  initial begin
    for (int i = 0; i < S; i++) begin pipe[i] = -1; dreg[i] = -1; end
    test_reset();
    test_full_rate();
    test_zero_beats();
    test_stall();
    test_bubbles();
    test_reset_in_drain();
`ifdef PIPE_CTRL_FLUSH_EN
    test_flush();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
